apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Two-requester APB master that shares a single APB bus among two command sources. Arbitrates round-robin, sequences each transfer through the APB SETUP/ACCESS phases, waits on PREADY with a bounded timeout, and returns read data and error status to the owning requester. Sits between the internal command sources and the APB slave (PSEL/PENABLE/PADDR/PWDATA/PSTRB/PPROT out; PRDATA/PREADY/PSLVERR in).

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width; PSTRB width is DATA_WIDTH/8
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort (≥2)
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- REQ0_VALID / REQ1_VALID  in  1  command pending; held with its command until ACK
- REQ0_WRITE / REQ1_WRITE  in  1  1 = write, 0 = read
- REQ0_ADDR / REQ1_ADDR  in  ADDR_WIDTH  transfer address
- REQ0_WDATA / REQ1_WDATA  in  DATA_WIDTH  write data
- REQ0_ACK / REQ1_ACK  out  1  one-cycle pulse: command captured
- REQ0_DONE / REQ1_DONE  out  1  one-cycle pulse: transfer complete
- RSP_RDATA  out  DATA_WIDTH  read data, valid with DONE
- RSP_ERR  out  1  error status, valid with DONE
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8; PPROT  out  3
- PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1

## Operation
- States: IDLE, SETUP, ACCESS. Reset → IDLE.
- IDLE: PSEL=0, PENABLE=0. If any VALID, grant per round-robin pointer, latch WRITE/ADDR/WDATA and owner ID, go SETUP. No VALID → stay.
- Arbitration: pointer resets to requester 0. Only one VALID → that one wins. Both VALID → pointer wins; after each grant pointer moves to the other requester.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, owner's ACK=1. → ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PREADY=1 → complete, go IDLE. PREADY=0 → increment wait counter; counter reaching TIMEOUT → abort, go IDLE.
- PADDR/PWRITE/PWDATA/PSTRB constant from SETUP through last ACCESS cycle; hold last values in IDLE.
- PSTRB = all ones on write, 0 on read. PPROT = 0 always.
- Completion: in the IDLE cycle following the last ACCESS cycle, owner's DONE=1; RSP_ERR = PSLVERR sampled with PREADY (1 on timeout); RSP_RDATA = PRDATA for reads, 0 for writes or timeout. RSP_RDATA/RSP_ERR hold until next DONE.
- Always returns through IDLE; no back-to-back SETUP.

## Timing
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, ACKs, DONEs, RSP_RDATA, RSP_ERR all 0; pointer = 0; counter = 0.
- VALID seen in IDLE cycle N → SETUP + ACK in N+1 → ACCESS in N+2 → zero-wait completion: DONE in N+3, IDLE; next grant possible at N+3 (SETUP N+4). Minimum 3 cycles per transfer.
- Each PREADY-low ACCESS cycle adds one cycle. Timeout: TIMEOUT consecutive PREADY-low ACCESS cycles, then IDLE with DONE+ERR; PREADY rising in the cycle after abort is ignored.
- VALID dropped before ACK: not an error; arbitration re-evaluates each IDLE cycle.
- ACK and DONE never both asserted to the same requester in the same cycle; at most one ACK and one DONE per cycle.
- PRESET mid-transfer: next edge → IDLE, all outputs to reset values, no DONE for aborted transfer, pointer = 0.

## Test plan
- Reset: PRESET=1 two cycles with REQ0_VALID=1 → PSEL=PENABLE=0, no ACK; release → ACK0 in the SETUP cycle 1 after release.
- Single write, zero-wait: REQ0 write ADDR=0x4, WDATA=0xA5A5_0001, PREADY=1 → SETUP 1 cycle (PSEL=1, PENABLE=0, PSTRB=0xF), ACCESS 1 cycle, DONE0 next cycle, RSP_ERR=0.
- Read with 2 wait states: REQ1 read ADDR=0xF, slave PRDATA=0x1234_5678, PREADY low 2 cycles → ACCESS lasts 3 cycles, PSTRB=0, DONE1 with RSP_RDATA=0x1234_5678.
- Contention: both VALID continuously, 4 transfers → grants 0,1,0,1; each transfer separated by one IDLE cycle.
- Slave error/timeout: write to ADDR=1055 with PSLVERR=1 at PREADY → DONE with RSP_ERR=1; PREADY held 0 → abort after 16 ACCESS cycles, DONE with RSP_ERR=1, RSP_RDATA=0.
- Reset mid-ACCESS with PREADY=0 → next cycle PSEL=0, no DONE, next request granted to requester 0.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing with a
// bounded PREADY wait, and read data / error return to the owning requester.
module apb_master_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      REQ0_VALID,
    input  logic                      REQ0_WRITE,
    input  logic [ADDR_WIDTH-1:0]     REQ0_ADDR,
    input  logic [DATA_WIDTH-1:0]     REQ0_WDATA,
    input  logic                      REQ1_VALID,
    input  logic                      REQ1_WRITE,
    input  logic [ADDR_WIDTH-1:0]     REQ1_ADDR,
    input  logic [DATA_WIDTH-1:0]     REQ1_WDATA,
    output logic                      REQ0_ACK,
    output logic                      REQ1_ACK,
    output logic                      REQ0_DONE,
    output logic                      REQ1_DONE,
    output logic [DATA_WIDTH-1:0]     RSP_RDATA,
    output logic                      RSP_ERR,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_WIDTH-1:0]     PADDR,
    output logic [DATA_WIDTH-1:0]     PWDATA,
    output logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic [2:0]                PPROT,
    input  logic [DATA_WIDTH-1:0]     PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_ptr;
    logic                    r_owner;
    logic [CNT_WIDTH-1:0]    r_cnt;

    logic                    r_ack0;
    logic                    r_ack1;
    logic                    r_done0;
    logic                    r_done1;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic [STRB_WIDTH-1:0]   r_pstrb;

    logic                    w_grant;
    logic                    w_grant_id;
    logic                    w_finish;
    logic                    w_timeout;
    logic                    w_sel_write;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, arbitration decision and completion detection
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_id  = r_ptr;
        w_finish    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (REQ0_VALID || REQ1_VALID) begin
                    w_grant     = 1'b1;
                    w_grant_id  = (REQ0_VALID && REQ1_VALID) ? r_ptr : REQ1_VALID;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th PREADY-low ACCESS cycle
                    w_finish    = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_sel_write = w_grant_id ? REQ1_WRITE : REQ0_WRITE;
    assign w_sel_addr  = w_grant_id ? REQ1_ADDR  : REQ0_ADDR;
    assign w_sel_wdata = w_grant_id ? REQ1_WDATA : REQ0_WDATA;

    // Registered APB drive, handshakes and response capture
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            r_cnt       <= '0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
        end else begin
            r_ack0    <= w_grant && !w_grant_id;
            r_ack1    <= w_grant &&  w_grant_id;
            r_done0   <= w_finish && !r_owner;
            r_done1   <= w_finish &&  r_owner;
            r_psel    <= (w_state_nxt != ST_IDLE);
            r_penable <= (w_state_nxt == ST_ACCESS);
            if (w_grant) begin
                r_owner  <= w_grant_id;
                r_ptr    <= ~w_grant_id;
                r_cnt    <= '0;
                r_pwrite <= w_sel_write;
                r_paddr  <= w_sel_addr;
                r_pwdata <= w_sel_wdata;
                r_pstrb  <= {STRB_WIDTH{w_sel_write}};
            end
            if ((r_state == ST_ACCESS) && !PREADY && !w_timeout) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            if (w_finish) begin
                r_rsp_err   <= w_timeout || PSLVERR;
                r_rsp_rdata <= (w_timeout || r_pwrite) ? '0 : PRDATA;
            end
        end
    end

    assign REQ0_ACK  = r_ack0;
    assign REQ1_ACK  = r_ack1;
    assign REQ0_DONE = r_done0;
    assign REQ1_DONE = r_done1;
    assign RSP_RDATA = r_rsp_rdata;
    assign RSP_ERR   = r_rsp_err;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign PPROT     = 3'b000;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: a transaction-timeline reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_apb_master_arbiter;

    localparam int TMO = 16;

    logic        PCLK;
    logic        PRESET;
    logic        REQ0_VALID, REQ0_WRITE, REQ1_VALID, REQ1_WRITE;
    logic [31:0] REQ0_ADDR, REQ0_WDATA, REQ1_ADDR, REQ1_WDATA;
    logic        REQ0_ACK, REQ1_ACK, REQ0_DONE, REQ1_DONE;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;

    apb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_WRITE(REQ0_WRITE), .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
        .REQ1_VALID(REQ1_VALID), .REQ1_WRITE(REQ1_WRITE), .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
        .REQ0_ACK(REQ0_ACK), .REQ1_ACK(REQ1_ACK), .REQ0_DONE(REQ0_DONE), .REQ1_DONE(REQ1_DONE),
        .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 1;

    // Requester side
    bit          pend   [2];
    bit          c_write[2];
    logic [31:0] c_addr [2];
    logic [31:0] c_wdata[2];
    bit          rst_req   = 1'b0;
    bit          auto_mode = 1'b0;
    bit          keep_busy = 1'b0;

    // Slave plan for the next granted transfer
    bit          dir_plan  = 1'b1;
    int          dir_wait  = 0;
    bit          dir_err   = 1'b0;
    logic [31:0] dir_rdata = 32'h0;

    // Reference model: a transfer is a timeline anchored at its grant cycle
    bit          have_txn = 1'b0;
    int          t_grant, t_done, t_wait;
    bit          t_timeout, t_err, t_write, t_owner;
    bit          ptr = 1'b0;
    bit          e_psel, e_penable, e_pwrite, e_ack0, e_ack1, e_done0, e_done1, e_err;
    logic [31:0] e_paddr, e_pwdata, e_rdata;
    logic [3:0]  e_pstrb;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp_v);
        end
    endtask

    task automatic check_outputs();
        chk("PSEL",      64'(PSEL),      64'(e_psel));
        chk("PENABLE",   64'(PENABLE),   64'(e_penable));
        chk("PWRITE",    64'(PWRITE),    64'(e_pwrite));
        chk("PADDR",     64'(PADDR),     64'(e_paddr));
        chk("PWDATA",    64'(PWDATA),    64'(e_pwdata));
        chk("PSTRB",     64'(PSTRB),     64'(e_pstrb));
        chk("PPROT",     64'(PPROT),     64'(0));
        chk("REQ0_ACK",  64'(REQ0_ACK),  64'(e_ack0));
        chk("REQ1_ACK",  64'(REQ1_ACK),  64'(e_ack1));
        chk("REQ0_DONE", 64'(REQ0_DONE), 64'(e_done0));
        chk("REQ1_DONE", 64'(REQ1_DONE), 64'(e_done1));
        chk("RSP_RDATA", 64'(RSP_RDATA), 64'(e_rdata));
        chk("RSP_ERR",   64'(RSP_ERR),   64'(e_err));
    endtask

    task automatic set_cmd(input int r, input bit wr, input logic [31:0] a, input logic [31:0] d);
        pend[r]    = 1'b1;
        c_write[r] = wr;
        c_addr[r]  = a;
        c_wdata[r] = d;
    endtask

    task automatic random_stim();
        for (int r = 0; r < 2; r++) begin
            if (!pend[r]) begin
                if ($urandom % 4 == 0) set_cmd(r, 1'($urandom), $urandom, $urandom);
            end else if ($urandom % 16 == 0) begin
                pend[r] = 1'b0;
            end
        end
        rst_req = ($urandom % 300 == 0);
    endtask

    // Slave responds from the model's timeline, with noise outside ACCESS
    task automatic drive_slave();
        int k;
        bit in_acc;
        in_acc  = have_txn && (cyc > t_grant + 1) && (cyc < t_done);
        k       = cyc - t_grant - 2;
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom);
        PREADY  = 1'($urandom);
        if (in_acc) begin
            PREADY = (k == t_wait);
            if (k == t_wait) begin
                PSLVERR = t_err;
                if (dir_plan) PRDATA = dir_rdata;
            end
        end
    endtask

    // Computes the expected outputs of cycle cyc+1 from the inputs of cycle cyc
    task automatic model_update();
        int x;
        int w;
        int acc;
        bit win;
        bit er;
        x = cyc + 1;
        if (PRESET) begin
            have_txn = 1'b0;
            ptr      = 1'b0;
            e_pwrite = 1'b0;
            e_paddr  = '0;
            e_pwdata = '0;
            e_pstrb  = '0;
            e_rdata  = '0;
            e_err    = 1'b0;
        end else begin
            if (have_txn && cyc == t_done - 1) begin
                e_err   = t_timeout ? 1'b1 : PSLVERR;
                e_rdata = (!t_timeout && !t_write) ? PRDATA : 32'h0;
            end
            if ((!have_txn || cyc >= t_done) && (REQ0_VALID || REQ1_VALID)) begin
                win = (REQ0_VALID && REQ1_VALID) ? ptr : REQ1_VALID;
                if (dir_plan) begin
                    w  = dir_wait;
                    er = dir_err;
                end else begin
                    case ($urandom % 10)
                        0, 1, 2, 3, 4, 5: w = int'($urandom % 3);
                        6, 7:             w = int'($urandom_range(3, 8));
                        default:          w = int'($urandom_range(TMO - 2, TMO + 2));
                    endcase
                    er = ($urandom % 4 == 0);
                end
                acc       = (w + 1 < TMO) ? w + 1 : TMO;
                have_txn  = 1'b1;
                t_grant   = cyc;
                t_done    = cyc + 2 + acc;
                t_timeout = (w >= TMO);
                t_wait    = w;
                t_err     = er;
                t_owner   = win;
                t_write   = c_write[win];
                e_pwrite  = c_write[win];
                e_paddr   = c_addr[win];
                e_pwdata  = c_wdata[win];
                e_pstrb   = c_write[win] ? 4'hF : 4'h0;
                ptr       = ~win;
                pend[win] = 1'b0;
            end
        end
        e_psel    = have_txn && (x > t_grant) && (x < t_done);
        e_penable = have_txn && (x > t_grant + 1) && (x < t_done);
        e_ack0    = have_txn && (x == t_grant + 1) && !t_owner;
        e_ack1    = have_txn && (x == t_grant + 1) &&  t_owner;
        e_done0   = have_txn && (x == t_done) && !t_owner;
        e_done1   = have_txn && (x == t_done) &&  t_owner;
    endtask

    task automatic tick();
        @(negedge PCLK);
        check_outputs();
        if (auto_mode) random_stim();
        if (keep_busy) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r]) set_cmd(r, 1'($urandom), $urandom, $urandom);
        end
        PRESET     = rst_req;
        REQ0_VALID = pend[0]; REQ0_WRITE = c_write[0]; REQ0_ADDR = c_addr[0]; REQ0_WDATA = c_wdata[0];
        REQ1_VALID = pend[1]; REQ1_WRITE = c_write[1]; REQ1_ADDR = c_addr[1]; REQ1_WDATA = c_wdata[1];
        drive_slave();
        model_update();
        cyc++;
    endtask

    task automatic wait_done(input int r, input int budget, input string nm, output int acc);
        bit seen;
        seen = 1'b0;
        acc  = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (PSEL && PENABLE) acc++;
            if ((r == 0) ? REQ0_DONE : REQ1_DONE) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done_wait actual=no DONE%0d expected=DONE%0d within %0d cycles", nm, r, r, budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int n_acks;
        int grants [4];
        int ack_cyc[4];
        bit got;

        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; c_write[r] = 1'b0; c_addr[r] = '0; c_wdata[r] = '0;
        end
        e_psel = 0; e_penable = 0; e_pwrite = 0; e_ack0 = 0; e_ack1 = 0;
        e_done0 = 0; e_done1 = 0; e_err = 0;
        e_paddr = '0; e_pwdata = '0; e_rdata = '0; e_pstrb = '0;
        t_grant = 0; t_done = 0; t_wait = 0; t_timeout = 0; t_err = 0; t_write = 0; t_owner = 0;
        PRESET = 1'b1;
        REQ0_VALID = 0; REQ0_WRITE = 0; REQ0_ADDR = '0; REQ0_WDATA = '0;
        REQ1_VALID = 0; REQ1_WRITE = 0; REQ1_ADDR = '0; REQ1_WDATA = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        @(posedge PCLK);

        // Reset held two cycles with a pending request, then a zero-wait write
        rst_req = 1'b1;
        set_cmd(0, 1'b1, 32'h4, 32'hA5A5_0001);
        dir_wait = 0; dir_err = 1'b0;
        tick();
        tick();
        chk("rst_psel", 64'(PSEL), 64'(0));
        chk("rst_ack0", 64'(REQ0_ACK), 64'(0));
        rst_req = 1'b0;
        tick();
        tick();
        chk("wr_setup_ack0",    64'(REQ0_ACK), 64'(1));
        chk("wr_setup_psel",    64'(PSEL),     64'(1));
        chk("wr_setup_penable", 64'(PENABLE),  64'(0));
        chk("wr_setup_pstrb",   64'(PSTRB),    64'(4'hF));
        chk("wr_setup_paddr",   64'(PADDR),    64'(32'h4));
        chk("wr_setup_pwdata",  64'(PWDATA),   64'(32'hA5A5_0001));
        tick();
        chk("wr_access_penable", 64'(PENABLE), 64'(1));
        tick();
        chk("wr_done0", 64'(REQ0_DONE), 64'(1));
        chk("wr_err",   64'(RSP_ERR),   64'(0));
        chk("wr_idle_psel", 64'(PSEL),  64'(0));

        // Read from requester 1 with two wait states
        set_cmd(1, 1'b0, 32'hF, 32'h0);
        dir_wait = 2; dir_rdata = 32'h1234_5678;
        wait_done(1, 20, "rd", acc);
        chk("rd_access_cycles", 64'(acc),       64'(3));
        chk("rd_rdata",         64'(RSP_RDATA), 64'(32'h1234_5678));
        chk("rd_err",           64'(RSP_ERR),   64'(0));
        chk("rd_pstrb_held",    64'(PSTRB),     64'(0));

        // Contention: both requesters continuously valid
        dir_wait  = 0;
        keep_busy = 1'b1;
        n_acks    = 0;
        for (int i = 0; i < 40 && n_acks < 4; i++) begin
            tick();
            if (REQ0_ACK || REQ1_ACK) begin
                grants[n_acks]  = REQ1_ACK ? 1 : 0;
                ack_cyc[n_acks] = cyc;
                n_acks++;
            end
        end
        chk("cont_ack_count", 64'(n_acks), 64'(4));
        keep_busy = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        if (n_acks == 4) begin
            chk("cont_grant0", 64'(grants[0]), 64'(0));
            chk("cont_grant1", 64'(grants[1]), 64'(1));
            chk("cont_grant2", 64'(grants[2]), 64'(0));
            chk("cont_grant3", 64'(grants[3]), 64'(1));
            for (int i = 0; i < 3; i++)
                chk("cont_ack_spacing", 64'(ack_cyc[i+1] - ack_cyc[i]), 64'(3));
        end
        repeat (6) tick();

        // Slave error on a write, a clean read, then a read that times out
        set_cmd(0, 1'b1, 32'd1055, 32'h0BAD_0001);
        dir_err = 1'b1;
        wait_done(0, 20, "slverr", acc);
        chk("slverr_err", 64'(RSP_ERR), 64'(1));
        dir_err = 1'b0; dir_rdata = 32'hCAFE_F00D;
        set_cmd(1, 1'b0, 32'h20, 32'h0);
        wait_done(1, 20, "rd2", acc);
        chk("rd2_rdata", 64'(RSP_RDATA), 64'(32'hCAFE_F00D));
        set_cmd(0, 1'b0, 32'h24, 32'h0);
        dir_wait = 1000;
        wait_done(0, 40, "tmo", acc);
        chk("tmo_access_cycles", 64'(acc),       64'(16));
        chk("tmo_err",           64'(RSP_ERR),   64'(1));
        chk("tmo_rdata",         64'(RSP_RDATA), 64'(0));
        repeat (2) tick();

        // Reset in the middle of a stalled ACCESS
        set_cmd(0, 1'b0, 32'h30, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (PENABLE) got = 1'b1;
        end
        chk("mid_reach_access", 64'(got), 64'(1));
        repeat (2) tick();
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        tick();
        chk("mid_rst_psel",    64'(PSEL),      64'(0));
        chk("mid_rst_penable", 64'(PENABLE),   64'(0));
        chk("mid_rst_done0",   64'(REQ0_DONE), 64'(0));
        set_cmd(0, 1'b1, 32'h40, 32'h1111_2222);
        set_cmd(1, 1'b1, 32'h44, 32'h3333_4444);
        dir_wait = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (REQ0_ACK || REQ1_ACK) begin
                got = 1'b1;
                chk("post_rst_ack0", 64'(REQ0_ACK), 64'(1));
                chk("post_rst_ack1", 64'(REQ1_ACK), 64'(0));
            end
        end
        chk("post_rst_granted", 64'(got), 64'(1));
        repeat (8) tick();

        // Random traffic with occasional resets
        dir_plan  = 1'b0;
        auto_mode = 1'b1;
        repeat (3000) tick();
        auto_mode = 1'b0;
        rst_req   = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
